// File: rtl/mem_wb_pkg.sv
// Shared types and default widths for the MEM/WB stage and load extraction logic.
package mem_wb_pkg;

    localparam int unsigned DATA_W_DEF   = 64;
    localparam int unsigned REG_AW_DEF   = 5;
    localparam int unsigned ZERO_REG_DEF = 31;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC4  = 2'd2,
        WB_ZERO = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef struct packed {
        wb_sel_e  wb_sel;
        ld_size_e ld_size;
        logic     ld_signed;
        logic     reg_write;
    } wb_ctrl_t;

    // Field width in bits for a load size: 8, 16, 32, 64.
    function automatic int unsigned ld_bits(ld_size_e size);
        return 32'd8 << size;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Little-endian lane extraction plus sign/zero extension of a raw load word.
module load_extend
    import mem_wb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    localparam int unsigned OFF_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [OFF_W-1:0]  offset,
    input  ld_size_e          size,
    input  logic              sext,
    output logic [DATA_W-1:0] ext_data_c
);

    int unsigned       fw;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              sign_bit;

    // Bytes shifted in from above the top lane are zero; no wrap-around.
    always_comb begin
        fw         = ld_bits(size);
        shifted    = raw >> {offset, 3'b000};
        mask       = '0;
        sign_bit   = 1'b0;
        ext_data_c = shifted;
        if (fw < DATA_W) begin
            mask       = ~({DATA_W{1'b1}} << fw);
            sign_bit   = |(shifted & (DATA_W'(1) << (fw - 1)));
            ext_data_c = (shifted & mask) | ((sext && sign_bit) ? ~mask : '0);
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback source select and load extraction.
// Optional performance counters enabled by defining MEM_WB_PERF_EN.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned ZERO_REG = ZERO_REG_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        wb_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] dm_read_data,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    input  logic              reg_write,
    input  logic [REG_AW-1:0] rd,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data
`ifdef MEM_WB_PERF_EN
    ,
    output logic [63:0]       retired_cnt,
    output logic [31:0]       loads_cnt
`endif
);

    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    logic              valid_q;
    wb_ctrl_t          ctrl_d;
    wb_ctrl_t          ctrl_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] dm_q;
    logic [DATA_W-1:0] pc4_q;
    logic [DATA_W-1:0] load_val_c;

    always_comb begin
        ctrl_d.wb_sel    = wb_sel_e'(wb_sel);
        ctrl_d.ld_size   = ld_size_e'(ld_size);
        ctrl_d.ld_signed = ld_signed;
        ctrl_d.reg_write = reg_write;
    end

    // Flush beats stall; a flushed slot keeps its data but is no longer valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd_q    <= '0;
            alu_q   <= '0;
            dm_q    <= '0;
            pc4_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q <= in_valid;
            ctrl_q  <= ctrl_d;
            rd_q    <= rd;
            alu_q   <= alu_result;
            dm_q    <= dm_read_data;
            pc4_q   <= pc_plus4;
        end
    end

    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .raw        (dm_q),
        .offset     (alu_q[OFF_W-1:0]),
        .size       (ctrl_q.ld_size),
        .sext       (ctrl_q.ld_signed),
        .ext_data_c (load_val_c)
    );

    always_comb begin
        wb_data = '0;
        unique case (ctrl_q.wb_sel)
            WB_ALU:  wb_data = alu_q;
            WB_MEM:  wb_data = load_val_c;
            WB_PC4:  wb_data = pc4_q;
            WB_ZERO: wb_data = '0;
            default: wb_data = '0;
        endcase
    end

    assign wb_valid     = valid_q;
    assign wb_rd        = rd_q;
    assign wb_reg_write = valid_q & ctrl_q.reg_write & (rd_q != REG_AW'(ZERO_REG));

`ifdef MEM_WB_PERF_EN
    // An instruction retires on the cycle it leaves the stage unstalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt <= '0;
            loads_cnt   <= '0;
        end else if (valid_q && !stall) begin
            retired_cnt <= retired_cnt + 64'd1;
            if (ctrl_q.wb_sel == WB_MEM) begin
                loads_cnt <= loads_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
